// File: rtl/aes_key_pkg.sv
// Shared constants and types for the AES-192 round-key store.
package aes_key_pkg;

   localparam int unsigned AES192_NR    = 12;
   localparam int unsigned AES_RK_W     = 128;
   localparam int unsigned AES192_RK_AW = 4;
   localparam int unsigned AES192_MASK_W = AES192_NR + 1;

   typedef logic [AES192_MASK_W-1:0] rk_mask_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOADING = 2'd1,
      ST_READY   = 2'd2
   } rk_state_e;

endpackage

// File: rtl/aes_round_key_store_192_if.sv
// Load/read bus between the key expander, cipher datapath and the round-key store.
interface aes_round_key_store_192_if
   import aes_key_pkg::*;
#(
   parameter int unsigned KW = AES_RK_W,
   parameter int unsigned AW = AES192_RK_AW
) ();

   logic          start;
   logic [KW-1:0] key_hi;
   logic          skey_valid;
   logic [AW-1:0] skey_idx;
   logic [KW-1:0] skey;
   logic          key_clear;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic          rd_valid;
   logic [KW-1:0] rd_data;
   logic          rd_err;
   logic          keys_ready;
   logic          load_err;

   modport master (
      output start, key_hi, skey_valid, skey_idx, skey, key_clear, rd_en, rd_addr,
      input  rd_valid, rd_data, rd_err, keys_ready, load_err
   );

   modport slave (
      input  start, key_hi, skey_valid, skey_idx, skey, key_clear, rd_en, rd_addr,
      output rd_valid, rd_data, rd_err, keys_ready, load_err
   );

endinterface

// File: rtl/aes_rk_mem.sv
// Round-key flop array: one write port, one registered read port, synchronous clear-all.
module aes_rk_mem #(
   parameter int unsigned DEPTH = 13,
   parameter int unsigned KW    = 128,
   parameter int unsigned AW    = 4
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          clr,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [KW-1:0] wdata,
   input  logic          re,
   input  logic          rd_zero,
   input  logic [AW-1:0] raddr,
   output logic [KW-1:0] rdata
);

   logic [KW-1:0] mem [DEPTH];

   // Storage: clear dominates write; contents intentionally not reset.
   always_ff @(posedge clk) begin
      if (clr) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read register: forced to zero on rejected or clear-colliding reads, holds when idle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= rd_zero ? '0 : mem[raddr];
      end
   end

endmodule

// File: rtl/aes_round_key_store_192.sv
// AES-192 round-key store: captures key 0 at start and rounds 1..NR from the expander,
// then serves keys by index in any order.
module aes_round_key_store_192
   import aes_key_pkg::*;
#(
   parameter int unsigned NR = AES192_NR,
   parameter int unsigned KW = AES_RK_W,
   parameter int unsigned AW = AES192_RK_AW
) (
   input logic                       clk,
   input logic                       resetn,
   aes_round_key_store_192_if.slave  bus
);

   localparam int unsigned MW = NR + 1;

   rk_state_e     state_q, state_nxt;
   logic [MW-1:0] mask_q, mask_nxt;
   logic          load_err_q, load_err_nxt;
   logic          keys_ready_q;
   logic          rd_valid_q;
   logic          rd_err_q;

   logic          idx_ok_c;
   logic [MW-1:0] mask_set_c;
   logic          load_done_c;
   logic          rd_bad_c;

   logic          mem_clr;
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [KW-1:0] mem_wdata;

   // Index qualification and fill tracking for the incoming subkey.
   assign idx_ok_c    = (bus.skey_idx != '0) && (bus.skey_idx <= AW'(NR));
   assign mask_set_c  = mask_q | (MW'(1) << bus.skey_idx);
   assign load_done_c = &mask_set_c;

   // Reads are rejected until fully loaded or when the index is past the last round.
   assign rd_bad_c = !keys_ready_q || (bus.rd_addr > AW'(NR));

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Next-state: clear beats start beats subkey traffic.
   always_comb begin
      state_nxt = state_q;
      if (bus.key_clear) begin
         state_nxt = ST_IDLE;
      end else if (bus.start) begin
         state_nxt = ST_LOADING;
      end else if ((state_q == ST_LOADING) && bus.skey_valid && idx_ok_c && load_done_c) begin
         state_nxt = ST_READY;
      end
   end

   // Datapath controls: memory write/clear, fill mask and load error updates.
   always_comb begin
      mem_clr      = 1'b0;
      mem_we       = 1'b0;
      mem_waddr    = '0;
      mem_wdata    = '0;
      mask_nxt     = mask_q;
      load_err_nxt = load_err_q;
      if (bus.key_clear) begin
         mem_clr      = 1'b1;
         mask_nxt     = '0;
         load_err_nxt = 1'b0;
      end else if (bus.start) begin
         mem_we       = 1'b1;
         mem_wdata    = bus.key_hi;
         mask_nxt     = MW'(1);
         load_err_nxt = 1'b0;
      end else if ((state_q == ST_LOADING) && bus.skey_valid) begin
         if (idx_ok_c) begin
            mem_we    = 1'b1;
            mem_waddr = bus.skey_idx;
            mem_wdata = bus.skey;
            mask_nxt  = mask_set_c;
         end else begin
            load_err_nxt = 1'b1;
         end
      end
   end

   // Status and read-response registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mask_q       <= '0;
         load_err_q   <= 1'b0;
         keys_ready_q <= 1'b0;
         rd_valid_q   <= 1'b0;
         rd_err_q     <= 1'b0;
      end else begin
         mask_q       <= mask_nxt;
         load_err_q   <= load_err_nxt;
         keys_ready_q <= (state_nxt == ST_READY);
         rd_valid_q   <= bus.rd_en;
         rd_err_q     <= bus.rd_en & rd_bad_c;
      end
   end

   aes_rk_mem #(
      .DEPTH (MW),
      .KW    (KW),
      .AW    (AW)
   ) u_mem (
      .clk     (clk),
      .resetn  (resetn),
      .clr     (mem_clr),
      .we      (mem_we),
      .waddr   (mem_waddr),
      .wdata   (mem_wdata),
      .re      (bus.rd_en),
      .rd_zero (rd_bad_c | bus.key_clear),
      .raddr   (bus.rd_addr),
      .rdata   (bus.rd_data)
   );

   assign bus.rd_valid   = rd_valid_q;
   assign bus.rd_err     = rd_err_q;
   assign bus.keys_ready = keys_ready_q;
   assign bus.load_err   = load_err_q;

endmodule

// File: tb/tb_aes_round_key_store_192.sv
// Directed bench for the AES-192 round-key store using the FIPS-197 A.2 key schedule.
module tb_aes_round_key_store_192;

   logic clk;
   logic resetn;
   int   n_chk;
   int   n_err;
   logic [127:0] rk [13];

   aes_round_key_store_192_if bus ();

   aes_round_key_store_192 dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start pulse followed by the expander streaming idx 1..12 on consecutive cycles.
   task automatic do_load(input string tag);
      bus.start  = 1'b1;
      bus.key_hi = rk[0];
      tick();
      bus.start = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         bus.skey_valid = 1'b1;
         bus.skey_idx   = 4'(i);
         bus.skey       = rk[i];
         if (i == 12) chk({tag, "_rdy_early"}, 128'(bus.keys_ready), 128'd0);
         tick();
      end
      bus.skey_valid = 1'b0;
      chk({tag, "_rdy"}, 128'(bus.keys_ready), 128'd1);
   endtask

   task automatic rd_chk(input string tag, input logic [3:0] a, input logic e_err,
                         input logic [127:0] e_data);
      bus.rd_en   = 1'b1;
      bus.rd_addr = a;
      tick();
      bus.rd_en = 1'b0;
      chk({tag, "_v"}, 128'(bus.rd_valid), 128'd1);
      chk({tag, "_err"}, 128'(bus.rd_err), 128'(e_err));
      chk({tag, "_d"}, bus.rd_data, e_data);
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      rk[0]  = 128'h8e73b0f7da0e6452c810f32b809079e5;
      rk[1]  = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
      rk[2]  = 128'hec12068e6c827f6b0e7a95b95c56fec2;
      rk[3]  = 128'h4db7b4bd69b5411885a74796e92538fd;
      rk[4]  = 128'he75fad44bb095386485af05721efb14f;
      rk[5]  = 128'ha448f6d94d6dce24aa326360113b30e6;
      rk[6]  = 128'ha25e7ed583b1cf9a27f939436a94f767;
      rk[7]  = 128'hc0a69407d19da4e1ec1786eb6fa64971;
      rk[8]  = 128'h485f703222cb8755e26d135233f0b7b3;
      rk[9]  = 128'h40beeb282f18a2596747d26b458c553e;
      rk[10] = 128'ha7e1466c9411f1df821f750aad07d753;
      rk[11] = 128'hca4005388fcc5006282d166abc3ce7b5;
      rk[12] = 128'he98ba06f448c773c8ecc720401002202;

      bus.start      = 1'b0;
      bus.key_hi     = '0;
      bus.skey_valid = 1'b0;
      bus.skey_idx   = '0;
      bus.skey       = '0;
      bus.key_clear  = 1'b0;
      bus.rd_en      = 1'b0;
      bus.rd_addr    = '0;
      resetn = 1'b1;
      #1 resetn = 1'b0;
      tick();
      tick();
      chk("rst_ready", 128'(bus.keys_ready), 128'd0);
      chk("rst_valid", 128'(bus.rd_valid), 128'd0);
      chk("rst_err", 128'(bus.rd_err), 128'd0);
      chk("rst_lerr", 128'(bus.load_err), 128'd0);
      chk("rst_data", bus.rd_data, 128'd0);
      resetn = 1'b1;
      tick();

      // 1: full load then first and last key
      do_load("t1");
      chk("t1_lerr", 128'(bus.load_err), 128'd0);
      rd_chk("t1_rd0", 4'd0, 1'b0, rk[0]);
      rd_chk("t1_rd12", 4'd12, 1'b0, rk[12]);

      // 2: back-to-back descending reads, then out-of-range index
      begin
         int pulses;
         pulses = 0;
         bus.rd_en = 1'b1;
         for (int a = 12; a >= 0; a--) begin
            bus.rd_addr = 4'(a);
            tick();
            if (bus.rd_valid) pulses++;
            chk($sformatf("t2_err%0d", a), 128'(bus.rd_err), 128'd0);
            chk($sformatf("t2_d%0d", a), bus.rd_data, rk[a]);
         end
         bus.rd_en = 1'b0;
         chk("t2_pulses", 128'(pulses), 128'd13);
      end
      rd_chk("t2_oor", 4'd13, 1'b1, 128'd0);
      rd_chk("t2_after", 4'd4, 1'b0, rk[4]);
      tick();
      chk("t2_idle_v", 128'(bus.rd_valid), 128'd0);
      chk("t2_hold_d", bus.rd_data, rk[4]);

      // 3: read mid-load is rejected; restart at cycle 7 delays ready
      bus.start  = 1'b1;
      bus.key_hi = rk[0];
      tick();
      bus.start = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         bus.skey_valid = 1'b1;
         bus.skey_idx   = 4'(i);
         bus.skey       = rk[i];
         if (i == 5) begin
            bus.rd_en   = 1'b1;
            bus.rd_addr = 4'd3;
         end
         tick();
         if (i == 5) begin
            bus.rd_en = 1'b0;
            chk("t3_rd_v", 128'(bus.rd_valid), 128'd1);
            chk("t3_rd_err", 128'(bus.rd_err), 128'd1);
            chk("t3_rd_d", bus.rd_data, 128'd0);
         end
      end
      bus.skey_valid = 1'b0;
      chk("t3_not_ready", 128'(bus.keys_ready), 128'd0);
      do_load("t3");

      // 4: bad indices flag load_err without corrupting entries
      bus.start  = 1'b1;
      bus.key_hi = rk[0];
      tick();
      bus.start      = 1'b0;
      bus.skey_valid = 1'b1;
      bus.skey_idx   = 4'd0;
      bus.skey       = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
      tick();
      chk("t4_lerr0", 128'(bus.load_err), 128'd1);
      bus.skey_idx = 4'd13;
      tick();
      chk("t4_lerr13", 128'(bus.load_err), 128'd1);
      chk("t4_not_ready", 128'(bus.keys_ready), 128'd0);
      for (int i = 1; i <= 12; i++) begin
         bus.skey_idx = 4'(i);
         bus.skey     = rk[i];
         tick();
      end
      bus.skey_valid = 1'b0;
      chk("t4_ready", 128'(bus.keys_ready), 128'd1);
      chk("t4_lerr_sticky", 128'(bus.load_err), 128'd1);
      rd_chk("t4_rd0", 4'd0, 1'b0, rk[0]);
      rd_chk("t4_rd1", 4'd1, 1'b0, rk[1]);

      // 5: clear colliding with a read, then clear+start
      bus.key_clear = 1'b1;
      bus.rd_en     = 1'b1;
      bus.rd_addr   = 4'd5;
      tick();
      bus.key_clear = 1'b0;
      bus.rd_en     = 1'b0;
      chk("t5_clr_v", 128'(bus.rd_valid), 128'd1);
      chk("t5_clr_err", 128'(bus.rd_err), 128'd0);
      chk("t5_clr_d", bus.rd_data, 128'd0);
      chk("t5_clr_ready", 128'(bus.keys_ready), 128'd0);
      chk("t5_clr_lerr", 128'(bus.load_err), 128'd0);
      rd_chk("t5_rd0", 4'd0, 1'b1, 128'd0);
      for (int i = 0; i <= 12; i++) begin
         chk($sformatf("t5_mem%0d", i), dut.u_mem.mem[i], 128'd0);
      end
      bus.key_clear = 1'b1;
      bus.start     = 1'b1;
      bus.key_hi    = rk[0];
      tick();
      bus.key_clear  = 1'b0;
      bus.start      = 1'b0;
      bus.skey_valid = 1'b1;
      for (int i = 0; i <= 12; i++) begin
         bus.skey_idx = 4'(i);
         bus.skey     = rk[i];
         tick();
      end
      bus.skey_valid = 1'b0;
      chk("t5_cs_ready", 128'(bus.keys_ready), 128'd0);
      chk("t5_cs_lerr", 128'(bus.load_err), 128'd0);
      chk("t5_cs_mem0", dut.u_mem.mem[0], 128'd0);
      chk("t5_cs_mem12", dut.u_mem.mem[12], 128'd0);

      // 6: async reset mid-load
      do_load("t6a");
      bus.start   = 1'b1;
      bus.key_hi  = rk[0];
      bus.rd_en   = 1'b1;
      bus.rd_addr = 4'd7;
      tick();
      bus.start = 1'b0;
      chk("t6_rs_v", 128'(bus.rd_valid), 128'd1);
      chk("t6_rs_err", 128'(bus.rd_err), 128'd0);
      chk("t6_rs_d", bus.rd_data, rk[7]);
      chk("t6_rs_ready", 128'(bus.keys_ready), 128'd0);
      bus.rd_addr    = 4'd14;
      bus.skey_valid = 1'b1;
      bus.skey_idx   = 4'd0;
      tick();
      chk("t6_lerr", 128'(bus.load_err), 128'd1);
      for (int i = 1; i <= 4; i++) begin
         bus.skey_idx = 4'(i);
         bus.skey     = rk[i];
         tick();
      end
      bus.skey_idx = 4'd5;
      bus.skey     = rk[5];
      #2 resetn = 1'b0;
      #1;
      chk("t6_async_v", 128'(bus.rd_valid), 128'd0);
      chk("t6_async_err", 128'(bus.rd_err), 128'd0);
      chk("t6_async_d", bus.rd_data, 128'd0);
      chk("t6_async_ready", 128'(bus.keys_ready), 128'd0);
      chk("t6_async_lerr", 128'(bus.load_err), 128'd0);
      bus.rd_en = 1'b0;
      tick();
      resetn = 1'b1;
      for (int i = 6; i <= 12; i++) begin
         bus.skey_idx = 4'(i);
         bus.skey     = rk[i];
         tick();
      end
      bus.skey_valid = 1'b0;
      chk("t6_post_ready", 128'(bus.keys_ready), 128'd0);
      rd_chk("t6_post_rd", 4'd0, 1'b1, 128'd0);
      do_load("t6b");
      rd_chk("t6_final_rd", 4'd12, 1'b0, rk[12]);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
